// File: rtl/fixed_point_seq_mult.sv
// Radix-2 shift-add multiplier for sign-magnitude I.F fixed point.
// One multiplier bit per cycle; saturating result with overflow flag.
module fixed_point_seq_mult #(
  parameter int I     = 16,
  parameter int F     = 15,
  parameter int ROUND = 0,
  localparam int W    = 1 + I + F
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         ovf
);

  localparam int M  = W - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(M);
  localparam int MW = AW - F;

  localparam logic [AW-1:0] RND =
    (ROUND != 0) ? (AW'(1) << (F - 1)) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINAL,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    ma_q, ma_d;
  logic [M-1:0]    mb_q, mb_d;
  logic            sign_q, sign_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic            ovf_q, ovf_d;

  logic [AW-1:0]   addend;
  logic [AW-1:0]   acc_rnd;
  logic [MW-1:0]   mag_full;
  logic            sat;
  logic [M-1:0]    mag;

  // Result shaping: optional rounding, drop fraction, saturate.
  always_comb begin
    addend   = {{(AW-M){1'b0}}, ma_q} << cnt_q;
    acc_rnd  = acc_q + RND;
    mag_full = acc_rnd[AW-1:F];
    sat      = |mag_full[MW-1:M];
    mag      = sat ? {M{1'b1}} : mag_full[M-1:0];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ma_d    = a[M-1:0];
          mb_d    = b[M-1:0];
          sign_d  = a[W-1] ^ b[W-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mb_q[cnt_q]) acc_d = acc_q + addend;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) state_d = FINAL;
      end
      FINAL: begin
        out_d   = {sign_q & (|mag), mag};
        ovf_d   = sat;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_fixed_point_seq_mult.sv
// Bench for fixed_point_seq_mult: vector table, scoreboard,
// handshake, backpressure and reset corner cases.
module tb_fixed_point_seq_mult;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic [31:0] rout;
    logic        rovf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, ovf;
  logic [31:0] out;
  logic        r_in_ready, r_out_valid, r_ovf;
  logic [31:0] r_out;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t mon_e;

  fixed_point_seq_mult #(.I(16), .F(15), .ROUND(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf)
  );

  fixed_point_seq_mult #(.I(16), .F(15), .ROUND(1)) dut_r (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(r_in_ready),
    .a(a), .b(b),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .out(r_out), .ovf(r_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h",
                  nm, act, exp);
  endtask

  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t        r;
    logic [63:0] p, m;
    logic        s;
    p = 64'(x[30:0]) * 64'(y[30:0]);
    s = x[31] ^ y[31];
    m = p >> 15;
    r.ovf = (m >= 64'h8000_0000);
    r.out[30:0] = r.ovf ? 31'h7FFF_FFFF : m[30:0];
    r.out[31] = s && (r.out[30:0] != 0);
    m = (p + 64'h4000) >> 15;
    r.rovf = (m >= 64'h8000_0000);
    r.rout[30:0] = r.rovf ? 31'h7FFF_FFFF : m[30:0];
    r.rout[31] = s && (r.rout[30:0] != 0);
    return r;
  endfunction

  // Scoreboard pop on every completed output handshake.
  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %08h expected none",
                 out);
      end else begin
        mon_e = sb.pop_front();
        chk("out", out, mon_e.out);
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
        chk("rnd_out", r_out, mon_e.rout);
        chk("rnd_ovf", 32'(r_ovf), 32'(mon_e.rovf));
        chk("rnd_valid", 32'(r_out_valid), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] av,
                       input logic [31:0] bv,
                       input exp_t e,
                       input bit push,
                       output int acc_c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    if (push) sb.push_back(e);
    acc_c = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_valid(input int acc_c);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("latency", 32'(cyc - acc_c), 32'd32);
  endtask

  task automatic run(input logic [31:0] av,
                     input logic [31:0] bv,
                     input exp_t e);
    int ac;
    issue(av, bv, e, 1'b1, ac);
    wait_valid(ac);
    @(negedge clk);
    chk("ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    exp_t e;
    int   ac;
    logic [31:0] ho;
    logic        hv;

    tbl[0] = '{32'h0000C000, 32'h00010000,
      '{32'h00018000, 1'b0, 32'h00018000, 1'b0}};
    tbl[1] = '{32'h8000C000, 32'h00010000,
      '{32'h80018000, 1'b0, 32'h80018000, 1'b0}};
    tbl[2] = '{32'h8000C000, 32'h80010000,
      '{32'h00018000, 1'b0, 32'h00018000, 1'b0}};
    tbl[3] = '{32'h80000000, 32'h00008000,
      '{32'h00000000, 1'b0, 32'h00000000, 1'b0}};
    tbl[4] = '{32'h00800000, 32'h00800000,
      '{32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1}};
    tbl[5] = '{32'h80800000, 32'h00800000,
      '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1}};
    tbl[6] = '{32'h00000001, 32'h00004000,
      '{32'h00000000, 1'b0, 32'h00000001, 1'b0}};
    tbl[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF,
      '{32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1}};
    tbl[8] = '{32'h00008000, 32'h80000000,
      '{32'h00000000, 1'b0, 32'h00000000, 1'b0}};
    tbl[9] = '{32'h80000001, 32'h00004000,
      '{32'h00000000, 1'b0, 32'h80000001, 1'b0}};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run(tbl[i].a, tbl[i].b, tbl[i].e);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra = ra & 32'h800FFFFF;
        rb = rb & 32'h8003FFFF;
      end
      run(ra, rb, model(ra, rb));
    end

    // Operands offered while busy must be ignored.
    issue(32'h0000C000, 32'h00010000, tbl[0].e, 1'b1, ac);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_valid(ac);
    @(negedge clk);

    // Backpressure: result held while consumer stalls.
    out_ready = 1'b0;
    e = model(32'h80030000, 32'h00014000);
    issue(32'h80030000, 32'h00014000, e, 1'b1, ac);
    wait_valid(ac);
    ho = out;
    hv = ovf;
    chk("bp_value", ho, e.out);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out", out, ho);
      chk("bp_ovf", 32'(ovf), 32'(hv));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", 32'(in_ready), 32'd1);

    // Reset mid-operation discards the result.
    issue(32'h00018000, 32'h00018000, e, 1'b0, ac);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    run(32'h00008000, 32'h00008000,
        '{32'h00008000, 1'b0, 32'h00008000, 1'b0});

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
